// File: rtl/sampletest_arb.sv
// Round-robin arbiter feeding one sampletest pipe from NREQ sample iterators, with tag tracking and credit flow control.
// Optional triangle lock is enabled by defining SAMPTEST_ARB_TRI_LOCK_EN.
module sampletest_arb #(
    parameter int SIGFIG     = 24,
    parameter int VERTS      = 3,
    parameter int AXIS       = 3,
    parameter int COLORS     = 3,
    parameter int PIPE_DEPTH = 2,
    parameter int NREQ       = 4,
    parameter int CREDITS    = 8,
    localparam int TAGW      = $clog2(NREQ)
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic        [NREQ-1:0]                                  req_valid_R15H,
    input  logic        [NREQ-1:0]                                  req_last_R15H,
    input  logic signed [NREQ-1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri_R15S,
    input  logic        [NREQ-1:0][COLORS-1:0][SIGFIG-1:0]          req_color_R15U,
    input  logic signed [NREQ-1:0][1:0][SIGFIG-1:0]                 req_sample_R15S,
    output logic        [NREQ-1:0]                                  req_ready_R15H,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]           tri_R16S,
    output logic        [COLORS-1:0][SIGFIG-1:0]                    color_R16U,
    output logic signed [1:0][SIGFIG-1:0]                           sample_R16S,
    output logic                                                    validSamp_R16H,
    input  logic                                                    hit_valid_R18H,
    output logic        [TAGW-1:0]                                  hit_tag_R18U,
    output logic                                                    hit_tagvalid_R18H,
    input  logic                                                    credit_ret_H
);
    localparam int CW = $clog2(CREDITS + 1);

    logic [TAGW-1:0] rr_ptr;
    logic [CW-1:0]   credits;
    logic            has_credit;
    logic            gnt_found;
    logic [TAGW-1:0] gnt_idx;
    logic            hs;
    logic [TAGW-1:0] tag_r16;
    logic [PIPE_DEPTH-1:0] vld_pipe;
    logic [TAGW-1:0]       tag_pipe [PIPE_DEPTH];

`ifdef SAMPTEST_ARB_TRI_LOCK_EN
    logic            locked;
    logic [TAGW-1:0] lock_idx;
`else
    logic unused_last;
    assign unused_last = ^req_last_R15H;
`endif

    assign has_credit = (credits != '0);

    always_comb begin
        int cand;
        gnt_found      = 1'b0;
        gnt_idx        = '0;
        req_ready_R15H = '0;
        cand           = 0;
`ifdef SAMPTEST_ARB_TRI_LOCK_EN
        // A locked requester owns the pipe even while its valid is low.
        if (locked) begin
            gnt_found = has_credit;
            gnt_idx   = lock_idx;
        end else begin
`else
        begin
`endif
            for (int k = 0; k < NREQ; k++) begin
                cand = (int'(rr_ptr) + k) % NREQ;
                if (!gnt_found && has_credit && req_valid_R15H[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = TAGW'(cand);
                end
            end
        end
        if (gnt_found && !rst)
            req_ready_R15H[gnt_idx] = 1'b1;
        hs = |(req_ready_R15H & req_valid_R15H);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr         <= '0;
            credits        <= CW'(CREDITS);
            validSamp_R16H <= 1'b0;
            tri_R16S       <= '0;
            color_R16U     <= '0;
            sample_R16S    <= '0;
            tag_r16        <= '0;
            vld_pipe       <= '0;
            for (int s = 0; s < PIPE_DEPTH; s++)
                tag_pipe[s] <= '0;
`ifdef SAMPTEST_ARB_TRI_LOCK_EN
            locked   <= 1'b0;
            lock_idx <= '0;
`endif
        end else begin
            validSamp_R16H <= hs;
            if (hs) begin
                tri_R16S    <= req_tri_R15S[gnt_idx];
                color_R16U  <= req_color_R15U[gnt_idx];
                sample_R16S <= req_sample_R15S[gnt_idx];
                tag_r16     <= gnt_idx;
                rr_ptr      <= TAGW'((int'(gnt_idx) + 1) % NREQ);
`ifdef SAMPTEST_ARB_TRI_LOCK_EN
                locked   <= !req_last_R15H[gnt_idx];
                lock_idx <= gnt_idx;
`endif
            end
            // Tag pipe starts at R16 so its tail lines up with sampletest's R18.
            vld_pipe[0] <= validSamp_R16H;
            tag_pipe[0] <= tag_r16;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
            if (hs && !credit_ret_H)
                credits <= credits - CW'(1);
            else if (!hs && credit_ret_H && credits != CW'(CREDITS))
                credits <= credits + CW'(1);
        end
    end

    assign hit_tag_R18U      = tag_pipe[PIPE_DEPTH-1];
    assign hit_tagvalid_R18H = vld_pipe[PIPE_DEPTH-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(credit_ret_H && !hs && credits == CW'(CREDITS)));
            assert (!hit_valid_R18H || hit_tagvalid_R18H);
        end
    end
endmodule

// File: tb/tb_sampletest_arb.sv
// Scoreboard bench for sampletest_arb: grant order, credit limits, tag timing and reset flush.
module tb_sampletest_arb;
    localparam int SIGFIG = 24, VERTS = 3, AXIS = 3, COLORS = 3;
    localparam int PD = 2, NREQ = 4, CREDITS = 8, TAGW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_last = '1;
    logic signed [NREQ-1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri;
    logic [NREQ-1:0][COLORS-1:0][SIGFIG-1:0] req_color;
    logic signed [NREQ-1:0][1:0][SIGFIG-1:0] req_sample;
    logic [NREQ-1:0] req_ready;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S;
    logic [COLORS-1:0][SIGFIG-1:0] color_R16U;
    logic signed [1:0][SIGFIG-1:0] sample_R16S;
    logic validSamp;
    logic hit_valid = 1'b0;
    logic [TAGW-1:0] hit_tag;
    logic hit_tagvalid;
    logic credit_ret = 1'b0;

    sampletest_arb #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
                     .PIPE_DEPTH(PD), .NREQ(NREQ), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst),
        .req_valid_R15H(req_valid), .req_last_R15H(req_last),
        .req_tri_R15S(req_tri), .req_color_R15U(req_color), .req_sample_R15S(req_sample),
        .req_ready_R15H(req_ready),
        .tri_R16S(tri_R16S), .color_R16U(color_R16U), .sample_R16S(sample_R16S),
        .validSamp_R16H(validSamp),
        .hit_valid_R18H(hit_valid), .hit_tag_R18U(hit_tag), .hit_tagvalid_R18H(hit_tagvalid),
        .credit_ret_H(credit_ret)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int tag; } ent_t;
    ent_t sb[$];
    int cyc = 0;
    int vectors = 0;
    int fails = 0;
    logic hit_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // R18 monitor: an expected tag is due exactly PD+1 cycles after its grant.
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                if (hit_tagvalid !== 1'b1 || hit_tag !== TAGW'(sb[0].tag)) begin
                    fails++;
                    $display("FAIL r18_tag cyc=%0d got valid=%b tag=%0d want valid=1 tag=%0d",
                             cyc, hit_tagvalid, hit_tag, sb[0].tag);
                end
                void'(sb.pop_front());
            end else if (hit_tagvalid !== 1'b0) begin
                fails++;
                $display("FAIL r18_idle cyc=%0d got valid=%b want 0", cyc, hit_tagvalid);
            end
        end
    end

    task automatic cycle(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                         input logic c, output logic [NREQ-1:0] rdy);
        @(posedge clk);
        #1;
        rst = r;
        if (r) sb.delete();
        req_valid  = v;
        req_last   = l;
        credit_ret = c;
        hit_valid  = hit_mode && sb.size() > 0 && sb[0].due == cyc && sb[0].tag == 3;
        @(negedge clk);
        rdy = req_ready;
    endtask

    task automatic push_tag(input int g);
        sb.push_back('{due: cyc + 1 + PD, tag: g});
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] rdy;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 4'b1111, 4'b1111, 1'b0, rdy);
            vectors++;
            if (rdy !== 4'b0000) begin
                fails++; $display("FAIL reset_ready got %b want 0000", rdy);
            end
        end
        cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
        vectors++;
        if (validSamp !== 1'b0 || tri_R16S !== '0 || color_R16U !== '0 || sample_R16S !== '0) begin
            fails++; $display("FAIL reset_r16 got valid=%b sample=%h", validSamp, sample_R16S);
        end
        vectors++;
        if (hit_tagvalid !== 1'b0 || hit_tag !== '0) begin
            fails++; $display("FAIL reset_r18 got valid=%b tag=%0d want 0 0", hit_tagvalid, hit_tag);
        end
        vectors++;
        if (int'(dut.credits) != CREDITS) begin
            fails++; $display("FAIL reset_credits got %0d want %0d", dut.credits, CREDITS);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] rdy;
        int prev_g = -1;
        int exp_g;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) cycle(1'b0, 4'b1111, 4'b1111, 1'b1, rdy);
            else       cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
            exp_g = (k < 8) ? k % 4 : -1;
            vectors++;
            if (rdy !== ((exp_g < 0) ? 4'b0000 : 4'(1 << exp_g))) begin
                fails++; $display("FAIL rr_grant k=%0d got %b want idx %0d", k, rdy, exp_g);
            end
            if (exp_g >= 0) push_tag(exp_g);
            if (prev_g >= 0) begin
                vectors++;
                if (validSamp !== 1'b1 || sample_R16S !== req_sample[prev_g] ||
                    tri_R16S !== req_tri[prev_g] || color_R16U !== req_color[prev_g]) begin
                    fails++;
                    $display("FAIL rr_r16_data k=%0d got valid=%b sample=%h want sample=%h",
                             k, validSamp, sample_R16S, req_sample[prev_g]);
                end
            end
            prev_g = exp_g;
        end
    endtask

    task automatic test_credit_limit();
        logic [NREQ-1:0] rdy;
        logic [NREQ-1:0] want;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 4'b0100, 4'b1111, 1'b0, rdy);
            want = (k < 8) ? 4'b0100 : 4'b0000;
            vectors++;
            if (rdy !== want) begin
                fails++; $display("FAIL credit_grant k=%0d got %b want %b", k, rdy, want);
            end
            if (k < 8) push_tag(2);
        end
        cycle(1'b0, 4'b0100, 4'b1111, 1'b1, rdy);
        vectors++;
        if (rdy !== 4'b0000) begin
            fails++; $display("FAIL credit_same_cycle_return got %b want 0000", rdy);
        end
        cycle(1'b0, 4'b0100, 4'b1111, 1'b0, rdy);
        vectors++;
        if (rdy !== 4'b0100) begin
            fails++; $display("FAIL credit_after_return got %b want 0100", rdy);
        end
        push_tag(2);
        cycle(1'b0, 4'b0100, 4'b1111, 1'b0, rdy);
        vectors++;
        if (rdy !== 4'b0000) begin
            fails++; $display("FAIL credit_exhausted_again got %b want 0000", rdy);
        end
        for (int k = 0; k < 8; k++) cycle(1'b0, 4'b0000, 4'b1111, 1'b1, rdy);
        cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
        vectors++;
        if (int'(dut.credits) != CREDITS) begin
            fails++; $display("FAIL credit_refill got %0d want %0d", dut.credits, CREDITS);
        end
    endtask

    task automatic test_same_cycle();
        logic [NREQ-1:0] rdy;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 4'b1000, 4'b1111, 1'b0, rdy);
            push_tag(3);
        end
        cycle(1'b0, 4'b1000, 4'b1111, 1'b1, rdy);
        vectors++;
        if (int'(dut.credits) != 3 || rdy !== 4'b1000) begin
            fails++; $display("FAIL same_pre got credits=%0d rdy=%b want 3 1000", dut.credits, rdy);
        end
        push_tag(3);
        cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
        vectors++;
        if (int'(dut.credits) != 3) begin
            fails++; $display("FAIL same_cycle_credits got %0d want 3", dut.credits);
        end
        for (int k = 0; k < 5; k++) cycle(1'b0, 4'b0000, 4'b1111, 1'b1, rdy);
        cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
    endtask

    task automatic test_hit_tag();
        logic [NREQ-1:0] rdy;
        int exp_g;
        int nhit = 0;
        hit_mode = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) cycle(1'b0, 4'b1010, 4'b1111, 1'b1, rdy);
            else       cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
            if (k < 4) begin
                exp_g = (k % 2 == 0) ? 1 : 3;
                vectors++;
                if (rdy !== 4'(1 << exp_g)) begin
                    fails++; $display("FAIL hit_grant k=%0d got %b want idx %0d", k, rdy, exp_g);
                end
                push_tag(exp_g);
            end
            if (hit_valid) begin
                nhit++;
                vectors++;
                if (hit_tag !== 2'd3 || hit_tagvalid !== 1'b1) begin
                    fails++; $display("FAIL hit_tag got tag=%0d valid=%b want 3 1", hit_tag, hit_tagvalid);
                end
            end
        end
        hit_mode = 1'b0;
        vectors++;
        if (nhit != 2) begin
            fails++; $display("FAIL hit_count got %0d want 2", nhit);
        end
    endtask

    task automatic test_reset_inflight();
        logic [NREQ-1:0] rdy;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 4'b1111, 4'b1111, 1'b0, rdy);
            vectors++;
            if (rdy !== 4'(1 << (k % 4))) begin
                fails++; $display("FAIL inflight_grant k=%0d got %b want idx %0d", k, rdy, k % 4);
            end
            push_tag(k % 4);
        end
        cycle(1'b1, 4'b0000, 4'b1111, 1'b0, rdy);
        cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
        vectors++;
        if (hit_tagvalid !== 1'b0 || validSamp !== 1'b0 || int'(dut.credits) != CREDITS) begin
            fails++;
            $display("FAIL inflight_reset got tagvalid=%b valid=%b credits=%0d want 0 0 %0d",
                     hit_tagvalid, validSamp, dut.credits, CREDITS);
        end
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
            vectors++;
            if (hit_tagvalid !== 1'b0) begin
                fails++; $display("FAIL inflight_drain k=%0d got %b want 0", k, hit_tagvalid);
            end
        end
    endtask

    task automatic test_tri_lock();
        logic [NREQ-1:0] rdy;
        logic [NREQ-1:0] lasts [4] = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
`ifdef SAMPTEST_ARB_TRI_LOCK_EN
        int exp_g [4] = '{1, 1, 1, 2};
`else
        int exp_g [4] = '{1, 2, 0, 1};
`endif
        cycle(1'b0, 4'b0001, 4'b1111, 1'b1, rdy);
        vectors++;
        if (rdy !== 4'b0001) begin
            fails++; $display("FAIL lock_setup got %b want 0001", rdy);
        end
        push_tag(0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 4'b0111, lasts[k], 1'b1, rdy);
            vectors++;
            if (rdy !== 4'(1 << exp_g[k])) begin
                fails++; $display("FAIL lock_grant k=%0d got %b want idx %0d", k, rdy, exp_g[k]);
            end
            push_tag(exp_g[k]);
        end
        cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
    endtask

    initial begin
        logic [NREQ-1:0] rdy;
        for (int i = 0; i < NREQ; i++) begin
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++)
                    req_tri[i][v][a] = SIGFIG'(i * 9 + v * 3 + a - 50);
            for (int c = 0; c < COLORS; c++)
                req_color[i][c] = SIGFIG'(i * 3 + c + 7);
            req_sample[i][0] = SIGFIG'(i + 100);
            req_sample[i][1] = SIGFIG'(-(i + 1));
        end
        test_reset();
        test_round_robin();
        test_credit_limit();
        test_same_cycle();
        test_hit_tag();
        test_reset_inflight();
        test_tri_lock();
        for (int k = 0; k < 6; k++) cycle(1'b0, 4'b0000, 4'b1111, 1'b0, rdy);
        vectors++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/sampletest_arb.md
# sampletest_arb

Round-robin arbiter that shares one `sampletest` pipeline between `NREQ` sample iterators in the raster stage. It registers the winning requester's triangle, color and sample into the R16 inputs of `sampletest`. A tag shift register tracks each sample through the fixed-latency pipe, so every R18 hit leaves tagged with its requester index. A credit counter bounds in-flight samples to the capacity of the downstream hit buffer; `sampletest` has no stall input, so this is the only way to avoid overflowing that buffer.

## Interface
- `SIGFIG`, 24, bits in color and position
- `VERTS`, 3, vertices per triangle
- `AXIS`, 3, axes per vertex
- `COLORS`, 3, color channels
- `PIPE_DEPTH`, 2, R16→R18 latency of `sampletest`, ≥1
- `NREQ`, 4, number of requesters, 2..8
- `CREDITS`, 8, downstream hit-buffer entries, ≥1
- `TAGW`, `$clog2(NREQ)`, tag width (localparam)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid_R15H`  in  `[NREQ]`  requester i offers a sample
- `req_last_R15H`  in  `[NREQ]`  sample is the last of its triangle
- `req_tri_R15S`  in  `[NREQ][VERTS][AXIS]×SIGFIG` signed  triangle
- `req_color_R15U`  in  `[NREQ][COLORS]×SIGFIG`  color
- `req_sample_R15S`  in  `[NREQ][2]×SIGFIG` signed  sample location
- `req_ready_R15H`  out  `[NREQ]`  accept; one-hot or zero
- `tri_R16S`, `color_R16U`, `sample_R16S`  out  as above  registered operands to `sampletest`
- `validSamp_R16H`  out  1  operand valid
- `hit_valid_R18H`  in  1  hit flag from `sampletest`
- `hit_tag_R18U`  out  `TAGW`  requester index aligned with `hit_valid_R18H`
- `hit_tagvalid_R18H`  out  1  an issued sample's result is present at R18 this cycle
- `credit_ret_H`  in  1  downstream freed one hit-buffer entry

## Operation
- Eligible: `req_valid_R15H[i]` is high and `credits > 0`.
- Grant: first eligible i searching from `rr_ptr` upward, mod `NREQ`.
  - `req_ready_R15H[i]` is combinational, high only for the granted i.
  - Handshake = valid & ready.
- On handshake:
  - Register the granted data into the R16 outputs and set `validSamp_R16H` = 1.
  - `rr_ptr` ← i+1 mod `NREQ`.
  - Push i into tag pipe stage 0.
- No handshake: `validSamp_R16H` = 0. R16 data holds its previous value (don't-care).
- Tag pipe: `PIPE_DEPTH` stages of {valid, tag}, shifting every cycle.
  - The final stage drives `hit_tag_R18U` and `hit_tagvalid_R18H`.
- Credits: counter of width `$clog2(CREDITS+1)`.
  - Handshake alone: −1.
  - `credit_ret_H` alone: +1.
  - Both in the same cycle: unchanged.
  - Handshake at `credits == 1` with no return in that cycle: the counter reaches 0 and all `req_ready_R15H` drop the next cycle.
- Overflow: `credit_ret_H` at `credits == CREDITS` with no handshake saturates the counter and fires an immediate assertion.
- Downstream returns one credit per issued sample, hit or miss.

## Timing
- Handshake in cycle N → `validSamp_R16H` in N+1 → `hit_tagvalid_R18H` and `hit_tag_R18U` in N+1+`PIPE_DEPTH`.
- Throughput: one sample per cycle while credits remain.
- `credit_ret_H` in cycle N can enable a grant in N+1, not in N.
- Reset values:
  - `validSamp_R16H` = 0; all R16 data outputs = 0.
  - `req_ready_R15H` = 0 during reset.
  - `hit_tag_R18U` = 0; `hit_tagvalid_R18H` = 0; tag pipe cleared.
  - `rr_ptr` = 0; `credits` = `CREDITS`; lock cleared.
- Reset mid-operation drops all in-flight tags. Downstream must be reset in the same cycle.

## Configuration
- Macro: `SAMPTEST_ARB_TRI_LOCK_EN`.
- Defined — triangle lock:
  - A handshake with `req_last_R15H[i]` = 0 locks the grant to i.
  - While locked, only i is eligible, even if i drops valid; a locked requester with no credits stalls everyone.
  - A handshake with `req_last_R15H[i]` = 1 releases the lock and sets `rr_ptr` ← i+1.
- Undefined: `req_last_R15H` is ignored; arbitration is per sample.

## Test plan
- Reset, then all four requesters valid, `CREDITS`=8, `credit_ret_H` tied high → grants 0,1,2,3,0,… on consecutive cycles; each tag appears at R18 `PIPE_DEPTH`+1 cycles after its grant.
- Only requester 2 valid, no credit return → exactly 8 handshakes, then `req_ready_R15H` = 0; one `credit_ret_H` pulse → one more grant on the next cycle.
- Handshake and `credit_ret_H` in the same cycle at `credits` = 3 → counter stays 3.
- Drive `hit_valid_R18H` = 1 for the sample from requester 3, otherwise 0 → `hit_tag_R18U` = 3 with `hit_tagvalid_R18H` = 1 in exactly that cycle.
- `rst` asserted with 5 samples in flight → next cycle `hit_tagvalid_R18H` = 0 and `credits` = 8, and nothing drains afterward.
- With `SAMPTEST_ARB_TRI_LOCK_EN` defined: requester 1 sends 3 samples, last flagged on the third, while 0 and 2 are valid throughout → grants 1,1,1 then 2.
